// File: rtl/mbist_pkg.sv
// mbist_pkg: shared state, op encoding and March C- element tables for the MBIST controller.
package mbist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int NUM_ELEM = 6;
  typedef logic [2:0] elem_t;
  // bit0 = write, bit1 = logical data value
  typedef enum logic [1:0] {R0 = 2'b00, W0 = 2'b01, R1 = 2'b10, W1 = 2'b11} op_t;
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN = 6'b011000;
  localparam logic [NUM_ELEM-1:0] ELEM_PAIR = 6'b011110;
  localparam logic [2*NUM_ELEM-1:0] ELEM_OP_A = {R0, R1, R0, R1, R0, W0};
  localparam logic [2*NUM_ELEM-1:0] ELEM_OP_B = {R0, W0, W1, W0, W1, R0};
  localparam int TOTAL_OPS = 2560;
  function automatic op_t elem_op(input elem_t e, input logic second);
    return op_t'(second ? ELEM_OP_B[{e, 1'b0} +: 2] : ELEM_OP_A[{e, 1'b0} +: 2]);
  endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: loadable up/down address counter with a last-address flag for the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              ld_down,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb begin
    addr_d = ld ? (ld_down ? '1 : '0) : en ? (down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1)) : addr_q;
    last = down ? addr_q == '0 : addr_q == '1;
    addr = addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) addr_q <= '0;
    else addr_q <= addr_d;
  end
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST controller with first-failure capture.
// Define MBIST_DIAG_EN to run past mismatches and count them on fail_count.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] BG = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
`ifdef MBIST_DIAG_EN
  output logic [7:0]        fail_count,
`endif
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  state_t state_q, state_d;
  elem_t elem_q, elem_d, cmp_elem_q, cmp_elem_d, fail_elem_q, fail_elem_d;
  logic phase_q, phase_d, rd_pend_q, rd_pend_d, fail_q, fail_d;
  logic [DATA_W-1:0] exp_q, exp_d, op_data;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d, addr;
  logic run, op_done, elem_end, seq_end, mismatch, addr_last, ag_ld, ag_ld_down, ag_en, ag_down;
  op_t op;
`ifdef MBIST_DIAG_EN
  logic [7:0] fail_count_q, fail_count_d;
  assign fail_count = fail_count_q;
`endif
  assign ag_down = ELEM_DOWN[elem_q];
  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .ld(ag_ld), .ld_down(ag_ld_down), .en(ag_en), .down(ag_down),
    .addr(addr), .last(addr_last)
  );
  always_comb begin
    op = elem_op(elem_q, phase_q);
    run = state_q == RUN;
    op_data = op[1] ? ~BG : BG;
    op_done = !ELEM_PAIR[elem_q] || phase_q;
    elem_end = op_done && addr_last;
    seq_end = elem_end && elem_q == elem_t'(NUM_ELEM - 1);
    // the read issued last cycle is checked while the next op goes out
    mismatch = rd_pend_q && (run || state_q == DRAIN) && mem_read_data != exp_q;
    busy = run || state_q == DRAIN;
    done = state_q == DONE;
    mem_write_en = run && op[0];
    mem_read_en = run && !op[0];
    mem_addr = run ? addr : '0;
    mem_write_data = mem_write_en ? op_data : '0;
    rd_pend_d = mem_read_en;
    exp_d = op_data;
    cmp_addr_d = addr;
    cmp_elem_d = elem_q;
    state_d = state_q;
    elem_d = elem_q;
    phase_d = phase_q;
    ag_ld = 1'b0;
    ag_en = 1'b0;
    fail_d = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
`ifdef MBIST_DIAG_EN
    fail_count_d = fail_count_q;
`endif
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        elem_d = '0;
        phase_d = 1'b0;
        ag_ld = 1'b1;
        fail_d = 1'b0;
        fail_addr_d = '0;
        fail_elem_d = '0;
`ifdef MBIST_DIAG_EN
        fail_count_d = '0;
`endif
      end
      RUN: begin
        phase_d = !op_done;
        ag_en = op_done && !addr_last;
        ag_ld = elem_end && !seq_end;
        elem_d = ag_ld ? elem_q + 3'd1 : elem_q;
        state_d = seq_end ? DRAIN : RUN;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (mismatch) begin
      fail_d = 1'b1;
      fail_addr_d = fail_q ? fail_addr_q : cmp_addr_q;
      fail_elem_d = fail_q ? fail_elem_q : cmp_elem_q;
`ifdef MBIST_DIAG_EN
      fail_count_d = fail_count_q + {7'd0, fail_count_q != 8'hFF};
`else
      state_d = DONE;
`endif
    end
    ag_ld_down = ELEM_DOWN[elem_d];
    fail = fail_q;
    fail_addr = fail_addr_q;
    fail_elem = fail_elem_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      elem_q <= '0;
      phase_q <= 1'b0;
      rd_pend_q <= 1'b0;
      exp_q <= '0;
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
`ifdef MBIST_DIAG_EN
      fail_count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      phase_q <= phase_d;
      rd_pend_q <= rd_pend_d;
      exp_q <= exp_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_elem_q <= cmp_elem_d;
      fail_q <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
`ifdef MBIST_DIAG_EN
      fail_count_q <= fail_count_d;
`endif
    end
  end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: randomized fault-injection bench with a string-table March C- reference model.
module tb_mbist_march_ctrl;
  import mbist_pkg::*;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, fail, mem_write_en, mem_read_en;
  logic [7:0] fail_addr, mem_addr, mem_write_data, mem_read_data;
  logic [2:0] fail_elem;
`ifdef MBIST_DIAG_EN
  logic [7:0] fail_count;
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif
  typedef struct packed {logic we; logic re; logic [7:0] a; logic [7:0] d;} op_rec_t;
  op_rec_t obs[$], exp_ops[$];
  logic [7:0] mem [256];
  logic [7:0] sa1 [256];
  logic [7:0] sa0 [256];
  int n_cmp = 0, n_bad = 0;
  int done_edge, busy_cnt, rw_both;
  logic [13:0] c1_snap;
  logic m_fail;
  logic [7:0] m_addr, m_count;
  logic [2:0] m_elem;
  int m_done;

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
`ifdef MBIST_DIAG_EN
    .fail_count(fail_count),
`endif
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // 256x8 test memory with per-bit stuck-at faults applied on read
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_read_en) mem_read_data <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      sa1[i] = 8'h00;
      sa0[i] = 8'h00;
    end
  endtask

  // Walks the March C- elements as text and predicts op stream and outcome.
  task automatic model();
    string el [6];
    string s;
    logic [7:0] mm [256];
    logic [7:0] v;
    bit w;
    int a, k, limit;
    el = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    exp_ops.delete();
    m_fail = 1'b0; m_addr = 8'h00; m_elem = 3'd0; m_count = 8'd0;
    m_done = TOTAL_OPS + 1;
    k = 0;
    limit = TOTAL_OPS;
    for (int e = 0; e < NUM_ELEM; e++)
      for (int i = 0; i < 256; i++) begin
        a = (e == 3 || e == 4) ? 255 - i : i;
        s = el[e];
        for (int j = 0; j < s.len(); j += 2) begin
          if (k < limit) begin
            w = s[j] == "w";
            v = s[j+1] == "1" ? 8'hFF : 8'h00;
            k++;
            exp_ops.push_back({w, !w, a[7:0], w ? v : 8'h00});
            if (w) mm[a] = v;
            else if (((mm[a] | sa1[a]) & ~sa0[a]) != v) begin
              if (!m_fail) begin
                m_fail = 1'b1; m_addr = a[7:0]; m_elem = e[2:0];
                if (!DIAG) begin
                  m_done = k + 1;
                  limit = k + 1;
                end
              end
              if (m_count != 8'hFF) m_count++;
            end
          end
        end
      end
  endtask

  function automatic int first_diff();
    if (obs.size() != exp_ops.size()) return -2;
    foreach (obs[i]) if (obs[i] !== exp_ops[i]) return i;
    return -1;
  endfunction

  // Pulses start, then records ops/busy/done per cycle; returns right after a mid-run reset edge if rst_at>0.
  task automatic run_march(input int pulse_at, input int rst_at);
    int n;
    n = 0;
    obs.delete();
    done_edge = -1; busy_cnt = 0; rw_both = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    while (n < 2600) begin
      @(negedge clk);
      n++;
      start = n == pulse_at;
      if (n == 1) c1_snap = {busy, done, fail, fail_addr, fail_elem};
      if (mem_write_en || mem_read_en)
        obs.push_back({mem_write_en, mem_read_en, mem_addr, mem_write_en ? mem_write_data : 8'h00});
      if (mem_write_en && mem_read_en) rw_both++;
      if (busy) busy_cnt++;
      if (rst_at > 0 && n == rst_at + 1) return;
      if (n == rst_at) rst = 1'b0;
      if (done && done_edge < 0) done_edge = n - 1;
      if (done_edge >= 0 && n >= done_edge + 4) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, fail, fail_addr, fail_elem} !== 14'h0) begin n_bad++; $display("FAIL reset_status: got %h expected 0", {busy, done, fail, fail_addr, fail_elem}); end
    n_cmp++; if ({mem_write_en, mem_read_en, mem_addr, mem_write_data} !== 18'h0) begin n_bad++; $display("FAIL reset_mem: got %h expected 0", {mem_write_en, mem_read_en, mem_addr, mem_write_data}); end
`ifdef MBIST_DIAG_EN
    n_cmp++; if (fail_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", fail_count); end
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, mem_write_en, mem_read_en} !== 4'h0) begin n_bad++; $display("FAIL idle_quiet: got %b expected 0000", {busy, done, mem_write_en, mem_read_en}); end
  endtask

  task automatic test_clean();
    int nz;
    clear_faults();
    model();
    run_march(0, 0);
    n_cmp++; if (done_edge !== 2561) begin n_bad++; $display("FAIL clean_done_edge: got %0d expected 2561", done_edge); end
    n_cmp++; if (busy_cnt !== m_done || c1_snap[13] !== 1'b1) begin n_bad++; $display("FAIL clean_busy: got %0d cycles expected %0d", busy_cnt, m_done); end
    n_cmp++; if (first_diff() !== -1) begin n_bad++; $display("FAIL clean_ops: first diff at %0d, got %0d ops expected %0d", first_diff(), obs.size(), exp_ops.size()); end
    n_cmp++; if ({done, fail} !== 2'b10) begin n_bad++; $display("FAIL clean_status: got done,fail=%b expected 10", {done, fail}); end
    n_cmp++; if (rw_both !== 0) begin n_bad++; $display("FAIL clean_rw_overlap: got %0d expected 0", rw_both); end
    nz = 0;
    foreach (mem[i]) if (mem[i] !== 8'h00) nz++;
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL clean_mem_zero: got %0d nonzero words expected 0", nz); end
  endtask

  task automatic test_sa1_10();
    clear_faults();
    sa1[8'h10] = 8'h01;
    model();
    run_march(0, 0);
    n_cmp++; if ({fail, fail_addr, fail_elem} !== {1'b1, 8'h10, 3'd1} || {m_fail, m_addr, m_elem} !== {1'b1, 8'h10, 3'd1}) begin n_bad++; $display("FAIL sa1_diag: got %b/%h/%0d expected 1/10/1", fail, fail_addr, fail_elem); end
    n_cmp++; if (done_edge !== m_done) begin n_bad++; $display("FAIL sa1_done_edge: got %0d expected %0d", done_edge, m_done); end
    n_cmp++; if (first_diff() !== -1) begin n_bad++; $display("FAIL sa1_ops: first diff at %0d, got %0d ops expected %0d", first_diff(), obs.size(), exp_ops.size()); end
    n_cmp++; if (busy_cnt !== m_done) begin n_bad++; $display("FAIL sa1_busy: got %0d cycles expected %0d", busy_cnt, m_done); end
  endtask

  task automatic test_sa0_80();
    clear_faults();
    sa0[8'h80] = 8'h80;
    model();
    run_march(0, 0);
    n_cmp++; if ({fail, fail_addr, fail_elem} !== {1'b1, 8'h80, 3'd2}) begin n_bad++; $display("FAIL sa0_diag: got %b/%h/%0d expected 1/80/2", fail, fail_addr, fail_elem); end
    n_cmp++; if (done_edge !== m_done) begin n_bad++; $display("FAIL sa0_done_edge: got %0d expected %0d", done_edge, m_done); end
    n_cmp++; if (first_diff() !== -1) begin n_bad++; $display("FAIL sa0_ops: first diff at %0d, got %0d ops expected %0d", first_diff(), obs.size(), exp_ops.size()); end
  endtask

  task automatic test_reset_mid();
    clear_faults();
    run_march(0, 1000);
    n_cmp++; if ({busy, done, fail, fail_addr, fail_elem} !== 14'h0) begin n_bad++; $display("FAIL midrst_status: got %h expected 0", {busy, done, fail, fail_addr, fail_elem}); end
    n_cmp++; if ({mem_write_en, mem_read_en, mem_addr, mem_write_data} !== 18'h0) begin n_bad++; $display("FAIL midrst_mem: got %h expected 0", {mem_write_en, mem_read_en, mem_addr, mem_write_data}); end
    rst = 1'b1;
    @(negedge clk);
    model();
    run_march(0, 0);
    n_cmp++; if (done_edge !== m_done || fail !== 1'b0) begin n_bad++; $display("FAIL midrst_rerun: got edge %0d fail %b expected %0d 0", done_edge, fail, m_done); end
    n_cmp++; if (first_diff() !== -1) begin n_bad++; $display("FAIL midrst_ops: first diff at %0d", first_diff()); end
  endtask

  task automatic test_ignored_start();
    clear_faults();
    model();
    run_march(500, 0);
    n_cmp++; if (done_edge !== 2561) begin n_bad++; $display("FAIL ignstart_done_edge: got %0d expected 2561", done_edge); end
    n_cmp++; if (first_diff() !== -1) begin n_bad++; $display("FAIL ignstart_ops: first diff at %0d", first_diff()); end
  endtask

  task automatic test_back_to_back();
    clear_faults();
    sa1[8'h33] = 8'h40;
    model();
    run_march(0, 0);
    n_cmp++; if ({fail, fail_addr, fail_elem} !== {m_fail, m_addr, m_elem}) begin n_bad++; $display("FAIL b2b_first: got %b/%h/%0d expected %b/%h/%0d", fail, fail_addr, fail_elem, m_fail, m_addr, m_elem); end
    clear_faults();
    model();
    run_march(0, 0);
    n_cmp++; if (c1_snap !== 14'h2000) begin n_bad++; $display("FAIL b2b_clear: got %h expected 2000", c1_snap); end
    n_cmp++; if (done_edge !== m_done || fail !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got edge %0d fail %b expected %0d 0", done_edge, fail, m_done); end
  endtask

  task automatic test_random();
    int a, b, nf;
    for (int it = 0; it < 5; it++) begin
      clear_faults();
      nf = $urandom_range(1, 2);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
        else sa0[a][b] = 1'b1;
      end
      model();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_march($urandom_range(2, m_done - 1), 0);
      n_cmp++; if ({fail, fail_addr, fail_elem} !== {m_fail, m_addr, m_elem}) begin n_bad++; $display("FAIL rand%0d_diag: got %b/%h/%0d expected %b/%h/%0d", it, fail, fail_addr, fail_elem, m_fail, m_addr, m_elem); end
      n_cmp++; if (done_edge !== m_done) begin n_bad++; $display("FAIL rand%0d_done_edge: got %0d expected %0d", it, done_edge, m_done); end
      n_cmp++; if (first_diff() !== -1 || rw_both !== 0) begin n_bad++; $display("FAIL rand%0d_ops: first diff at %0d overlap %0d expected -1 0", it, first_diff(), rw_both); end
    end
  endtask

`ifdef MBIST_DIAG_EN
  task automatic test_diag_count();
    clear_faults();
    sa1[8'h10] = 8'h01;
    sa0[8'h20] = 8'h08;
    model();
    run_march(0, 0);
    n_cmp++; if (fail_count !== 8'd5 || m_count !== 8'd5) begin n_bad++; $display("FAIL diag_count: got %0d expected 5", fail_count); end
    n_cmp++; if ({fail, fail_addr, fail_elem} !== {1'b1, 8'h10, 3'd1}) begin n_bad++; $display("FAIL diag_first: got %b/%h/%0d expected 1/10/1", fail, fail_addr, fail_elem); end
    n_cmp++; if (done_edge !== 2561) begin n_bad++; $display("FAIL diag_done_edge: got %0d expected 2561", done_edge); end
  endtask
`endif

  initial begin
    clear_faults();
    test_reset();
    test_clean();
    test_sa1_10();
    test_sa0_80();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_random();
`ifdef MBIST_DIAG_EN
    test_diag_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Memory BIST controller that sits directly upstream of the 256x8 test memory and drives its write_en/read_en/addr/write_data pins.
- Runs a March C- sequence over all 256 addresses and compares the memory's registered read_data against the expected data.
- Reports pass/fail and first-failure diagnostics to the JTAG-side control logic.

Parameters:
- ADDR_W, 8, memory address width; the sequence covers all 2^ADDR_W addresses.
- DATA_W, 8, memory data width.
- BG, 8'h00, data background. Logical "0" = BG, logical "1" = ~BG.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
- busy  out  1  high while the sequence runs.
- done  out  1  level, high from completion until the next start or reset.
- fail  out  1  mismatch detected; valid while done=1.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  march element index (0..5) of the first mismatch.
- mem_write_en  out  1  to memory write_en.
- mem_read_en  out  1  to memory read_en.
- mem_addr  out  ADDR_W  to memory addr.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read_data  in  DATA_W  from memory read_data; registered, valid one cycle after mem_read_en.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs are 0, including the mem_* outputs. Reset mid-run aborts immediately; memory contents are then undefined.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the last op is issued.
  - DRAIN -> DONE.
  - DONE -> RUN on start.
  - RUN -> DONE on the first mismatch (non-diag build).
- Elements:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
  - "up" runs address 0 to 255; "down" runs 255 to 0.
- One memory op is issued per clock. Total 256 + 4*512 + 256 = 2560 op cycles. mem_read_en and mem_write_en are never high together.
- Timing:
  - Call the edge where start is sampled E0. busy=1 after E0.
  - Op k is presented during cycle k, between E(k-1) and E(k).
  - Read pipeline: a read issued in cycle t captures its data at E(t). The controller compares it during cycle t+1 against the expected value registered alongside it (expected data, address, element). Compare runs in parallel with the next op; a write to the same address in cycle t+1 is legal.
  - The last read is issued in cycle 2560 and compared in DRAIN (cycle 2561). At E2561: busy=0, done=1.
- Mismatch (non-diag build):
  - At the edge ending the compare cycle, the controller registers fail=1, fail_addr and fail_elem, and goes to DONE (busy=0, done=1).
  - An op issued in that same cycle still reaches the memory; no further ops are issued.
- start while busy=1 is ignored. start in DONE clears done, fail, fail_addr and fail_elem at E0.
- Address counter wraps are internal only. The element changes after address 255 (up elements) or address 0 (down elements).

Optional Feature:
- Macro MBIST_DIAG_EN.
- Defined:
  - Adds output fail_count (8 bits, saturates at 255, reset 0, cleared on start).
  - A mismatch does not stop the test. fail_count increments once per mismatching compare. fail_addr/fail_elem hold the first mismatch. done is asserted at E2561 as in a clean run.
- Undefined: stop at the first mismatch as described above; there is no fail_count port.

Decomposition:
- Package mbist_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - element index type and NUM_ELEM=6;
  - op encoding (R0, W0, R1, W1);
  - per-element direction and op-pair constant tables;
  - TOTAL_OPS=2560.
- One sub-module, mbist_addr_gen: loadable up/down ADDR_W counter with a last-address flag.

Test Plan:
- Fault-free memory:
  - start at E0 gives busy=1 for cycles 1..2561, then done=1, fail=0 at E2561.
  - Memory reads back all 8'h00 afterwards.
- Stuck-at-1 on bit0 of address 8'h10:
  - fail=1, fail_elem=1, fail_addr=8'h10.
  - done=1 one edge after the compare of that read; no ops are issued afterwards.
- Stuck-at-0 on bit7 of address 8'h80: fail=1, fail_elem=2, fail_addr=8'h80.
- rst=0 at cycle 1000:
  - All outputs are 0 after that edge.
  - A new start completes at E2561 relative to the new start, with fail=0.
- Ignored start: a start pulse at cycle 500 of a run causes no change; done still occurs at E2561.
- MBIST_DIAG_EN, with a stuck-at-1 at 8'h10 and a stuck-at-0 at 8'h20:
  - fail_count=5 (three r0 failures plus two r1 failures).
  - fail_addr=8'h10, fail_elem=1, done at E2561.
